// File: rtl/bcd_time_counter.sv
// mm:ss BCD stopwatch counter with a parametrised minute modulus, up/down, toggle pause and a wrap pulse.
// Optional blink masks for adjust mode are built only when BLINK_EN is defined.
module bcd_time_counter #(
  parameter int MIN_LIMIT = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1hz,
  input  logic       tick_2hz,
  input  logic       select,
  input  logic       adjust,
  input  logic       pause,
  input  logic       down,
  output logic [3:0] seconds_ones,
  output logic [3:0] seconds_tens,
  output logic [3:0] minutes_ones,
  output logic [3:0] minutes_tens,
  output logic       rollover,
  output logic       blank_sec,
  output logic       blank_min
);

  // Top minute value held as two BCD digits so it can be compared digit-wise.
  localparam logic [3:0] MIN_TENS_MAX = 4'((MIN_LIMIT - 1) / 10);
  localparam logic [3:0] MIN_ONES_MAX = 4'((MIN_LIMIT - 1) % 10);

  function automatic logic [7:0] bcd_next(
    input logic [3:0] tens,
    input logic [3:0] ones,
    input logic [3:0] max_tens,
    input logic [3:0] max_ones,
    input logic       dn
  );
    logic [7:0] r;
    r = {tens, ones};
    if (dn) begin
      if (tens == 4'd0 && ones == 4'd0) r = {max_tens, max_ones};
      else if (ones == 4'd0)            r = {tens - 4'd1, 4'd9};
      else                              r = {tens, ones - 4'd1};
    end else begin
      if (tens == max_tens && ones == max_ones) r = 8'h00;
      else if (ones == 4'd9)                    r = {tens + 4'd1, 4'd0};
      else                                      r = {tens, ones + 4'd1};
    end
    return r;
  endfunction

  logic       pause_q;
  logic       paused;
  logic       step;
  logic       sec_wrap;
  logic       min_wrap;
  logic       sec_step;
  logic       min_step;
  logic [7:0] sec_next;
  logic [7:0] min_next;

  assign step     = (adjust ? tick_2hz : tick_1hz) & ~paused;
  assign sec_wrap = down ? (seconds_tens == 4'd0 && seconds_ones == 4'd0)
                         : (seconds_tens == 4'd5 && seconds_ones == 4'd9);
  assign min_wrap = down ? (minutes_tens == 4'd0 && minutes_ones == 4'd0)
                         : (minutes_tens == MIN_TENS_MAX && minutes_ones == MIN_ONES_MAX);

  // In adjust mode only the selected field moves; otherwise minutes follow the seconds carry/borrow.
  assign sec_step = step & (~adjust | ~select);
  assign min_step = step & (adjust ? select : sec_wrap);

  assign sec_next = bcd_next(seconds_tens, seconds_ones, 4'd5, 4'd9, down);
  assign min_next = bcd_next(minutes_tens, minutes_ones, MIN_TENS_MAX, MIN_ONES_MAX, down);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pause_q      <= 1'b0;
      paused       <= 1'b0;
      rollover     <= 1'b0;
      seconds_ones <= 4'd0;
      seconds_tens <= 4'd0;
      minutes_ones <= 4'd0;
      minutes_tens <= 4'd0;
    end else begin
      pause_q  <= pause;
      if (pause && !pause_q) paused <= ~paused;
      rollover <= step & ~adjust & sec_wrap & min_wrap;
      if (sec_step) {seconds_tens, seconds_ones} <= sec_next;
      if (min_step) {minutes_tens, minutes_ones} <= min_next;
    end
  end

`ifdef BLINK_EN
  logic blink;
  logic blink_next;

  // Masks are derived from the post-edge blink value so they line up with the blink register.
  assign blink_next = adjust ? (blink ^ tick_2hz) : 1'b0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink     <= 1'b0;
      blank_sec <= 1'b0;
      blank_min <= 1'b0;
    end else begin
      blink     <= blink_next;
      blank_sec <= adjust & ~select & blink_next;
      blank_min <= adjust & select & blink_next;
    end
  end
`else
  assign blank_sec = 1'b0;
  assign blank_min = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_time_counter.sv
// Directed bench for bcd_time_counter: a 60-minute instance and a 24-minute instance driven in lockstep.
module tb_bcd_time_counter;

  logic clk = 1'b0;
  logic rst, tick_1hz, tick_2hz, select, adjust, pause, down;
  logic [3:0] so, st, mo, mt;
  logic [3:0] so24, st24, mo24, mt24;
  logic rollover, blank_sec, blank_min;
  logic rollover24, blank_sec24, blank_min24;
  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  bcd_time_counter #(.MIN_LIMIT(60)) dut (
    .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .tick_2hz(tick_2hz),
    .select(select), .adjust(adjust), .pause(pause), .down(down),
    .seconds_ones(so), .seconds_tens(st), .minutes_ones(mo), .minutes_tens(mt),
    .rollover(rollover), .blank_sec(blank_sec), .blank_min(blank_min)
  );

  bcd_time_counter #(.MIN_LIMIT(24)) dut24 (
    .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .tick_2hz(tick_2hz),
    .select(select), .adjust(adjust), .pause(pause), .down(down),
    .seconds_ones(so24), .seconds_tens(st24), .minutes_ones(mo24), .minutes_tens(mt24),
    .rollover(rollover24), .blank_sec(blank_sec24), .blank_min(blank_min24)
  );

  wire [15:0] t60 = {mt, mo, st, so};
  wire [15:0] t24 = {mt24, mo24, st24, so24};

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // Each helper starts and ends on a falling edge, so outputs are sampled mid-cycle.
  task automatic applyStimulus(input int n1, input int n2);
    for (int i = 0; i < n1; i++) begin
      tick_1hz = 1'b1; @(negedge clk); tick_1hz = 1'b0;
    end
    for (int i = 0; i < n2; i++) begin
      tick_2hz = 1'b1; @(negedge clk); tick_2hz = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic doReset();
    rst = 1'b1; idle(2); rst = 1'b0; idle(1);
  endtask

  logic [3:0] exp_blink [4];

  initial begin
    rst = 1'b1; tick_1hz = 1'b0; tick_2hz = 1'b0;
    select = 1'b0; adjust = 1'b0; pause = 1'b0; down = 1'b0;
    idle(3);
    checkOutput("reset_time", t60, 16'h0000);
    checkOutput("reset_rollover", rollover, 0);
    checkOutput("reset_blank", {blank_sec, blank_min}, 0);
    rst = 1'b0; idle(1);

    // Up count through the minute carry
    applyStimulus(59, 0);
    checkOutput("up_0059", t60, 16'h0059);
    applyStimulus(1, 0);
    checkOutput("up_0100", t60, 16'h0100);
    applyStimulus(11, 0);
    checkOutput("up_0111", t60, 16'h0111);

    // Asynchronous reset mid-count at 12:34
    doReset();
    adjust = 1'b1; select = 1'b1; applyStimulus(0, 12);
    select = 1'b0; applyStimulus(0, 34);
    adjust = 1'b0;
    checkOutput("set_1234", t60, 16'h1234);
    #2 rst = 1'b1; #1;
    checkOutput("async_reset", t60, 16'h0000);
    @(negedge clk); idle(2);
    checkOutput("reset_held_rollover", rollover, 0);
    rst = 1'b0; idle(1);
    applyStimulus(1, 0);
    checkOutput("after_reset_tick", t60, 16'h0001);

    // Up wrap and down wrap on both moduli
    doReset();
    adjust = 1'b1; down = 1'b1;
    select = 1'b1; applyStimulus(0, 1);
    checkOutput("adj_min_down60", t60, 16'h5900);
    checkOutput("adj_min_down24", t24, 16'h2300);
    select = 1'b0; applyStimulus(0, 1);
    checkOutput("adj_sec_down", t60, 16'h5959);
    checkOutput("adj_no_rollover", rollover, 0);
    adjust = 1'b0; down = 1'b0;
    applyStimulus(1, 0);
    checkOutput("wrap_up60", t60, 16'h0000);
    checkOutput("wrap_up24", t24, 16'h0000);
    checkOutput("rollover_up60", rollover, 1);
    checkOutput("rollover_up24", rollover24, 1);
    idle(1);
    checkOutput("rollover_one_cycle", rollover, 0);
    down = 1'b1;
    applyStimulus(1, 0);
    checkOutput("wrap_down60", t60, 16'h5959);
    checkOutput("wrap_down24", t24, 16'h2359);
    checkOutput("rollover_down24", rollover24, 1);
    applyStimulus(1, 0);
    checkOutput("down_borrow_none", t60, 16'h5958);
    checkOutput("rollover_down_clear", rollover, 0);

    // Adjust mode: independent fields, tick_1hz ignored
    down = 1'b0; adjust = 1'b1; select = 1'b1;
    applyStimulus(0, 6);
    checkOutput("adj_min_up60", t60, 16'h0558);
    checkOutput("adj_min_up24", t24, 16'h0558);
    select = 1'b0; applyStimulus(0, 1);
    checkOutput("adj_sec_up", t60, 16'h0559);
    applyStimulus(0, 1);
    checkOutput("adj_sec_wrap", t60, 16'h0500);
    checkOutput("adj_wrap_no_rollover", rollover, 0);
    applyStimulus(1, 0);
    checkOutput("adj_ignores_1hz", t60, 16'h0500);
    select = 1'b1; down = 1'b1;
    applyStimulus(0, 6);
    checkOutput("adj_min_wrap60", t60, 16'h5900);
    checkOutput("adj_min_wrap24", t24, 16'h2300);
    adjust = 1'b0; down = 1'b0;

    // Pause: held level toggles once, strobe coincident with the edge still counts
    doReset();
    pause = 1'b1; idle(5); pause = 1'b0; idle(1);
    applyStimulus(3, 0);
    checkOutput("paused_hold", t60, 16'h0000);
    pause = 1'b1; idle(1); pause = 1'b0; idle(1);
    applyStimulus(1, 0);
    checkOutput("unpaused_tick", t60, 16'h0001);
    pause = 1'b1; applyStimulus(1, 0); pause = 1'b0;
    checkOutput("tick_with_pause_edge", t60, 16'h0002);
    applyStimulus(1, 0);
    checkOutput("paused_after_edge", t60, 16'h0002);
    adjust = 1'b1; applyStimulus(0, 1); adjust = 1'b0;
    checkOutput("paused_blocks_adjust", t60, 16'h0002);
    doReset();
    applyStimulus(1, 0);
    checkOutput("reset_unpauses", t60, 16'h0001);

    // Blink masks in adjust mode
`ifdef BLINK_EN
    exp_blink = '{4'd1, 4'd0, 4'd1, 4'd0};
`else
    exp_blink = '{4'd0, 4'd0, 4'd0, 4'd0};
`endif
    adjust = 1'b1; select = 1'b1; idle(1);
    checkOutput("blink_start", {blank_sec, blank_min}, 0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 1);
      checkOutput("blank_min_seq", {31'd0, blank_min}, {28'd0, exp_blink[i]});
      checkOutput("blank_sec_quiet", {31'd0, blank_sec}, 0);
    end
    adjust = 1'b0; idle(1);
    checkOutput("blank_off", {blank_sec, blank_min}, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
